// File: rtl/traffic_display_driver.sv
// Lamp decode, sequential double-dabble BCD conversion and 4-digit multiplexed 7-segment drive.
// Optional macro LEADING_ZERO_BLANK_EN blanks a lane's tens digit when it is zero.
module traffic_display_driver #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic [6:0] timeLane1,
    input  logic [6:0] timeLane2,
    output logic [2:0] lamp1,
    output logic [2:0] lamp2,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic [1:0] {S_IDLE, S_CONV1, S_CONV2, S_LOAD} conv_state_t;

    function automatic logic [6:0] clamp99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    // One double-dabble iteration on {bcd_tens, bcd_ones, binary}: adjust then shift.
    function automatic logic [14:0] dd_step(input logic [14:0] w);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = w[14:11];
        lo = w[10:7];
        if (lo >= 4'd5) lo = lo + 4'd3;
        if (hi >= 4'd5) hi = hi + 4'd3;
        return {hi[2:0], lo, w[6:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    conv_state_t        conv_q, conv_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [13:0]        shadow_q, shadow_d;
    logic [14:0]        work_q, work_d;
    logic [6:0]         snap2_q, snap2_d;
    logic [7:0]         res1_q, res1_d;
    logic [7:0]         disp1_q, disp1_d;
    logic [7:0]         disp2_q, disp2_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [2:0]         lamp1_q, lamp1_d;
    logic [2:0]         lamp2_q, lamp2_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;

    logic [14:0]        step_w;
    logic [3:0]         digit;
    logic               blank;

    always_comb begin
        conv_d      = conv_q;
        bit_cnt_d   = bit_cnt_q;
        shadow_d    = shadow_q;
        work_d      = work_q;
        snap2_d     = snap2_q;
        res1_d      = res1_q;
        disp1_d     = disp1_q;
        disp2_d     = disp2_q;
        scan_cnt_d  = scan_cnt_q;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        lamp1_d     = 3'b000;
        lamp2_d     = 3'b000;
        blank       = 1'b0;
        digit       = 4'd0;
        step_w      = dd_step(work_q);

        if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        case (state)
            3'd3: begin lamp1_d = LAMP_G; lamp2_d = LAMP_R; end
            3'd4: begin lamp1_d = LAMP_Y; lamp2_d = LAMP_R; end
            3'd5: begin lamp1_d = LAMP_R; lamp2_d = LAMP_G; end
            3'd6: begin lamp1_d = LAMP_R; lamp2_d = LAMP_Y; end
            default: begin
                blank   = 1'b1;
                lamp1_d = phase_q ? LAMP_Y : 3'b000;
                lamp2_d = phase_q ? LAMP_Y : 3'b000;
            end
        endcase

        // Shadow holds the raw inputs so an over-range value does not retrigger forever.
        case (conv_q)
            S_IDLE: begin
                if ({timeLane1, timeLane2} != shadow_q) begin
                    shadow_d  = {timeLane1, timeLane2};
                    work_d    = {8'd0, clamp99(timeLane1)};
                    snap2_d   = clamp99(timeLane2);
                    bit_cnt_d = 3'd0;
                    conv_d    = S_CONV1;
                end
            end
            S_CONV1: begin
                work_d    = step_w;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd6) begin
                    res1_d    = step_w[14:7];
                    work_d    = {8'd0, snap2_q};
                    bit_cnt_d = 3'd0;
                    conv_d    = S_CONV2;
                end
            end
            S_CONV2: begin
                work_d    = step_w;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd6) begin
                    bit_cnt_d = 3'd0;
                    conv_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                disp1_d = res1_q;
                disp2_d = work_q[14:7];
                conv_d  = S_IDLE;
            end
            default: conv_d = S_IDLE;
        endcase

        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end

        case (idx_q)
            2'd0:    digit = disp1_q[3:0];
            2'd1:    digit = disp1_q[7:4];
            2'd2:    digit = disp2_q[3:0];
            default: digit = disp2_q[7:4];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q[0] && (digit == 4'd0)) blank = 1'b1;
`endif
        an_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
        seg_d = blank ? 7'h7F : seg_encode(digit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_q      <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shadow_q    <= 14'd0;
            work_q      <= 15'd0;
            snap2_q     <= 7'd0;
            res1_q      <= 8'd0;
            disp1_q     <= 8'd0;
            disp2_q     <= 8'd0;
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            lamp1_q     <= 3'b000;
            lamp2_q     <= 3'b000;
            seg_q       <= 7'h7F;
            an_q        <= 4'hF;
        end else begin
            conv_q      <= conv_d;
            bit_cnt_q   <= bit_cnt_d;
            shadow_q    <= shadow_d;
            work_q      <= work_d;
            snap2_q     <= snap2_d;
            res1_q      <= res1_d;
            disp1_q     <= disp1_d;
            disp2_q     <= disp2_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            lamp1_q     <= lamp1_d;
            lamp2_q     <= lamp2_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign lamp1 = lamp1_q;
    assign lamp2 = lamp2_q;
    assign seg   = seg_q;
    assign an    = an_q;
    assign busy  = (conv_q != S_IDLE);
endmodule

// File: tb/tb_traffic_display_driver.sv
// Directed bench for traffic_display_driver with SCAN_DIV=4, BLINK_DIV=8.
module tb_traffic_display_driver;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] state;
    logic [6:0] timeLane1;
    logic [6:0] timeLane2;
    logic [2:0] lamp1;
    logic [2:0] lamp2;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    traffic_display_driver #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .reset(reset), .state(state), .timeLane1(timeLane1),
        .timeLane2(timeLane2), .lamp1(lamp1), .lamp2(lamp2), .seg(seg),
        .an(an), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Slot shown after edge k (edges counted from reset release) is ((k-1)/4)%4.
    task automatic goto_slot(input int s);
        for (int i = 0; i < 16; i++) begin
            if ((((cyc - 1) / 4) % 4) == s) return;
            tick(1);
        end
    endtask

    task automatic chk_digit(input string tag, input int slot, input int d);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << slot);
        goto_slot(slot);
        chk({tag, "_an"}, {3'b000, an}, {3'b000, exp_an});
        chk({tag, "_seg"}, seg, SEG[d]);
    endtask

    task automatic chk_tens_zero(input string tag, input int slot);
        goto_slot(slot);
`ifdef LEADING_ZERO_BLANK_EN
        chk({tag, "_an"}, {3'b000, an}, 7'h0F);
        chk({tag, "_seg"}, seg, 7'h7F);
`else
        chk({tag, "_an"}, {3'b000, an}, {3'b000, ~(4'b0001 << slot)});
        chk({tag, "_seg"}, seg, SEG[0]);
`endif
    endtask

    initial begin
        logic [3:0] sweep_an  [4];
        logic [6:0] sweep_seg [4];
        logic [2:0] fl;
        int a;
        sweep_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        sweep_seg = '{SEG[5], SEG[2], SEG[0], SEG[3]};

        reset = 1'b1; state = 3'd3; timeLane1 = 7'd25; timeLane2 = 7'd30;
        tick(3);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", {3'b000, an}, 7'h0F);
        chk("rst_lamp1", {4'b0, lamp1}, 7'd0);
        chk("rst_lamp2", {4'b0, lamp2}, 7'd0);
        chk("rst_busy", {6'b0, busy}, 7'd0);

        reset = 1'b0; cyc = 0;
        tick(1);
        chk("rel_lamp1", {4'b0, lamp1}, {4'b0, G});
        chk("rel_lamp2", {4'b0, lamp2}, {4'b0, R});
        chk("rel_busy", {6'b0, busy}, 7'd1);
        tick(14);
        chk("load_busy", {6'b0, busy}, 7'd1);
        tick(1);
        chk("idle_busy", {6'b0, busy}, 7'd0);

        // Display 25/30 is valid from edge 17; sweep a full scan period.
        for (int k = 0; k < 16; k++) begin
            tick(1);
            chk("sweep_an", {3'b000, an}, {3'b000, sweep_an[k / 4]});
            chk("sweep_seg", seg, sweep_seg[k / 4]);
        end

        state = 3'd4; tick(1);
        chk("yr_lamp1", {4'b0, lamp1}, {4'b0, Y});
        chk("yr_lamp2", {4'b0, lamp2}, {4'b0, R});
        state = 3'd5; tick(1);
        chk("rg_lamp1", {4'b0, lamp1}, {4'b0, R});
        chk("rg_lamp2", {4'b0, lamp2}, {4'b0, G});
        state = 3'd6; tick(1);
        chk("ry_lamp1", {4'b0, lamp1}, {4'b0, R});
        chk("ry_lamp2", {4'b0, lamp2}, {4'b0, Y});
        state = 3'd3; tick(1);
        chk("gr_lamp1", {4'b0, lamp1}, {4'b0, G});
        chk("gr_lamp2", {4'b0, lamp2}, {4'b0, R});

        timeLane1 = 7'd120;
        tick(20);
        chk_digit("clamp_ones", 0, 9);
        chk_digit("clamp_tens", 1, 9);

        timeLane1 = 7'd0;
        tick(20);
        chk_digit("zero_ones", 0, 0);
        chk_tens_zero("zero_tens", 1);
        chk_digit("l2_ones", 2, 0);
        chk_digit("l2_tens", 3, 3);

        // Fault: lamps after edge k blink Y while ((k-1)/8) is even.
        state = 3'd7;
        for (int k = 0; k < 24; k++) begin
            tick(1);
            fl = ((((cyc - 1) / 8) % 2) == 0) ? Y : 3'b000;
            chk("flt_lamp1", {4'b0, lamp1}, {4'b0, fl});
            chk("flt_lamp2", {4'b0, lamp2}, {4'b0, fl});
            chk("flt_an", {3'b000, an}, 7'h0F);
            chk("flt_seg", seg, 7'h7F);
        end
        state = 3'd3;
        tick(2);

        for (int i = 0; i < 16; i++) begin
            if ((cyc % 16) == 0) break;
            tick(1);
        end
        a = cyc;
        timeLane1 = 7'd10;
        tick(1);
        chk("mid_busy_c1", {6'b0, busy}, 7'd1);
        tick(2);
        timeLane1 = 7'd9;
        tick(12);
        chk("mid_busy_c15", {6'b0, busy}, 7'd1);
        tick(1);
        chk("mid_busy_c16", {6'b0, busy}, 7'd0);
        tick(1);
        chk("mid_busy_c17", {6'b0, busy}, 7'd1);
        chk_digit("mid10_ones", 0, 0);
        tick(4);
        chk_digit("mid10_tens", 1, 1);
        tick(10);
        chk("mid_busy_c31", {6'b0, busy}, 7'd1);
        tick(1);
        chk("mid_busy_c32", {6'b0, busy}, 7'd0);
        tick(1);
        chk_digit("mid9_ones", 0, 9);
        tick(4);
        chk_tens_zero("mid9_tens", 1);

        timeLane1 = 7'd42;
        tick(5);
        reset = 1'b1;
        tick(1);
        chk("abort_busy", {6'b0, busy}, 7'd0);
        chk("abort_an", {3'b000, an}, 7'h0F);
        reset = 1'b0; cyc = 0;
        tick(1);
        chk("abort_disp_an", {3'b000, an}, 7'b0001110);
        chk("abort_disp_seg", seg, SEG[0]);
        chk("abort_rebusy", {6'b0, busy}, 7'd1);
        chk("abort_lamp1", {4'b0, lamp1}, {4'b0, G});
        tick(16);
        chk_digit("l42_ones", 0, 2);
        chk_digit("l42_tens", 1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_display_driver.md
Name: traffic_display_driver

Overview:
- Consumer end of the traffic controller's `state` / `timeLane1` / `timeLane2` outputs.
- Decodes `state` into per-lane R/Y/G lamp drives.
- Converts both 7-bit countdowns to BCD with a sequential double-dabble FSM.
- Time-multiplexes four digits onto one common-anode 7-segment bus.
- Sits between the controller and the board pins.

Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays enabled (≥2).
- BLINK_DIV, 50000: clock cycles per half-period of the fault blink (≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- state  input  3  controller state: GR=3, YR=4, RG=5, RY=6; any other value is a fault.
- timeLane1  input  7  lane 1 remaining seconds.
- timeLane2  input  7  lane 2 remaining seconds.
- lamp1  output  3  lane 1 lamps {R,Y,G}, active-high, registered.
- lamp2  output  3  lane 2 lamps {R,Y,G}, active-high, registered.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  output  4  digit enables, active-low, registered; an[0]=L1 ones, an[1]=L1 tens, an[2]=L2 ones, an[3]=L2 tens.
- busy  output  1  high while the BCD conversion FSM is not IDLE.

Behaviour:
- One clock domain. Reset is synchronous and active-high, as already decided.
- Reset values:
  - lamp1=lamp2=3'b000, seg=7'h7F, an=4'hF, busy=0.
  - BCD display registers=0, shadow registers=0, digit index=0, scan and blink counters=0, blink phase=1, FSM=IDLE.
- Lamp decode (registered, 1-cycle latency from `state`):
  - GR → lamp1=G, lamp2=R.
  - YR → lamp1=Y, lamp2=R.
  - RG → lamp1=R, lamp2=G.
  - RY → lamp1=R, lamp2=Y.
  - Fault → lamp1=lamp2=Y when blink phase=1, else 000.
- Blink counter:
  - Free-runs 0..BLINK_DIV-1 and toggles the phase on wrap.
  - Runs regardless of state.
- Conversion FSM states: IDLE, CONV1, CONV2, LOAD.
  - IDLE: if {timeLane1,timeLane2} differs from shadow, capture both into shadow and snapshot, go CONV1 (capture cycle C).
    - Values >99 clamp to 99 at capture.
  - CONV1: 7 cycles (C+1..C+7) of double-dabble on the lane 1 snapshot. Each cycle: add 3 to any BCD nibble ≥5, then shift left 1.
  - CONV2: same, 7 cycles (C+8..C+14), on the lane 2 snapshot.
  - LOAD: at C+15, both BCD results are written to the display registers. They are visible on seg from the next scan slot onward. Then go IDLE.
  - Inputs changing during CONV/LOAD do not disturb the snapshot. IDLE recompares on the cycle after LOAD, so the newest value is always converted eventually.
  - Reset mid-conversion aborts to IDLE with display registers=0.
  - busy=1 in CONV1, CONV2, LOAD.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1; on wrap the digit index increments mod 4 (0→1→2→3→0).
  - Each cycle, an = one-hot-low of the index and seg = the encoding of the selected digit.
- Segment encoding, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Fault state: an=4'hF and seg=7'h7F (display blanked). Conversion still runs.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when a lane's tens digit is 0, its slot drives an=4'hF and seg=7'h7F (e.g. 7 shows as " 7").
- Undefined: tens digit 0 is displayed as '0' (e.g. "07").

Test Plan:
- Reset with SCAN_DIV=4, BLINK_DIV=8, state=3, L1=25, L2=30 → during reset seg=7F, an=F, lamps=000. Cycle after release: lamp1=001, lamp2=100. busy rises the cycle after capture; display registers read 25/30 at C+16.
- Scan sweep after conversion → an sequence 1110,1101,1011,0111 with each value held 4 cycles; seg = 0010010 ('5'), 0100100 ('2'), 1000000 ('0'), 0110000 ('3').
- L1=120 → lane 1 digits display 9,9 (clamp). L1=0 → ones='0'; tens blank if LEADING_ZERO_BLANK_EN defined, else '0'.
- Step state 3→4→5→6 one per cycle → lamp pairs (G,R),(Y,R),(R,G),(R,Y), each one cycle later.
- state=7 → an=F; lamps toggle between 010/010 and 000/000 every 8 cycles, starting on (phase=1 after reset).
- Change L1 10→9 at C+3 mid-conversion → 10 is loaded at C+15; new capture at C+16; 9 is loaded at C+31. Reset asserted at C+5 → busy=0 and display 0 the next cycle.
